// File: rtl/permute_round_engine.sv
// ============================================================================
// Module   : permute_round_engine
// Purpose  : Iterative bit-permutation engine. A block of NBYTES bytes is
//            accepted together with a 2-bit-per-round key schedule, then
//            ROUNDS rounds are applied, one per clock. Each round permutes
//            the bits inside every byte and rotates the byte lanes. Decrypt
//            mode applies the exact inverse sequence of rounds.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            in_valid/in_ready   input handshake
//            in_data             block, byte i = bits [8i+7:8i]
//            in_key              key schedule, round r uses [2r+1:2r]
//            in_decrypt          1 = inverse operation
//            out_valid/out_ready output handshake
//            out_data            result block (registered)
//            busy                high while a block is in flight
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module permute_round_engine #(
  parameter int NBYTES = 16,
  parameter int ROUNDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  input  logic [2*ROUNDS-1:0]   in_key,
  input  logic                  in_decrypt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  localparam int DW = 8 * NBYTES;
  localparam int CW = (ROUNDS + 1 > 1) ? $clog2(ROUNDS + 1) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       data_q, data_d;
  logic [2*ROUNDS-1:0] key_q, key_d;
  logic                dec_q, dec_d;
  logic                out_valid_q;

  logic [CW-1:0]       w_idx;
  logic [1:0]          w_k;
  logic [DW-1:0]       w_rot;
  logic [DW-1:0]       w_round;

  // All four byte permutations are self-inverse.
  function automatic logic [7:0] perm(input logic [7:0] b, input logic [1:0] k);
    logic [7:0] o;
    case (k)
      2'b00:   o = {b[6], b[7], b[4], b[5], b[2], b[3], b[0], b[1]};
      2'b01:   o = {b[3], b[2], b[1], b[0], b[7], b[6], b[5], b[4]};
      2'b10:   o = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
      default: o = {b[1], b[6], b[3], b[4], b[5], b[2], b[7], b[0]};
    endcase
    return o;
  endfunction

  // Decrypt walks the key schedule backwards.
  assign w_idx = dec_q ? (C_LAST - cnt_q) : cnt_q;

  always_comb begin
    w_k = 2'b00;
    for (int r = 0; r < ROUNDS; r++) begin
      if (w_idx == CW'(r)) w_k = key_q[2*r +: 2];
    end
  end

  // The same P is applied to every byte, so it commutes with the lane
  // rotation: both modes reduce to "rotate, then permute", differing only
  // in rotation direction.
  assign w_rot = dec_q ? {data_q[7:0], data_q[DW-1:8]}
                       : {data_q[DW-9:0], data_q[DW-1 -: 8]};

  generate
    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
      assign w_round[8*i +: 8] = perm(w_rot[8*i +: 8], w_k);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    key_d   = key_q;
    dec_d   = dec_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          key_d   = in_key;
          dec_d   = in_decrypt;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        data_d = w_round;
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      key_q       <= '0;
      dec_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      key_q       <= key_d;
      dec_q       <= dec_d;
      out_valid_q <= (state_d == S_DONE);
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  // data_q only changes in IDLE-accept and RUN, so it is stable in DONE.
  assign out_data  = data_q;

endmodule

`default_nettype wire
